// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator hall-call dispatcher: direction codes,
// FSM state encoding and the layout of one car's state word {floor, dir}.
package elevator_pkg;

  // Direction codes carried in the low two bits of each car state word.
  // 2'b10 is unused and is treated the same as idle.
  localparam logic [1:0] DIR_UP   = 2'b11;
  localparam logic [1:0] DIR_DOWN = 2'b01;
  localparam logic [1:0] DIR_IDLE = 2'b00;

  // Field layout inside one car state word.
  localparam int DIR_LSB   = 0;
  localparam int DIR_W     = 2;
  localparam int FLOOR_LSB = DIR_LSB + DIR_W;

  // Dispatcher FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EVAL  = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  // Bit offset of car 'car' inside the packed car_state bus.
  function automatic int car_lsb(input int car, input int floor_w);
    return car * (floor_w + DIR_W);
  endfunction

endpackage

// File: rtl/elevator_dispatcher_car_cost.sv
// Combinational scorer for one car against one hall-call floor.
// A car moving up is eligible when it is at or below the call, a car moving
// down when it is at or above; idle cars are always eligible. force_i makes
// any car eligible so that distance alone decides.
module car_cost
  import elevator_pkg::*;
#(
  parameter int FLOOR_W = 4
) (
  input  logic [FLOOR_W-1:0] floor_i,
  input  logic [1:0]         dir_i,
  input  logic [FLOOR_W-1:0] obj_i,
  input  logic               force_i,
  output logic               eligible_o,
  output logic [FLOOR_W-1:0] cost_o
);

  logic signed [FLOOR_W:0] diff;
  logic                    dir_ok;

  // Signed distance with one guard bit so floor differences never wrap.
  always_comb begin
    diff   = $signed({1'b0, floor_i}) - $signed({1'b0, obj_i});
    cost_o = diff[FLOOR_W] ? FLOOR_W'(-diff) : FLOOR_W'(diff);
    case (dir_i)
      DIR_UP:   dir_ok = diff[FLOOR_W] || (diff == '0);
      DIR_DOWN: dir_ok = !diff[FLOOR_W];
      DIR_IDLE: dir_ok = 1'b1;
      default:  dir_ok = 1'b1;
    endcase
    eligible_o = force_i || dir_ok;
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Sequential hall-call dispatcher for an N-car elevator group.
// Hall calls are latched into a per-floor pending mask. The FSM picks the
// next pending floor round-robin (SCAN), scores one car per cycle (EVAL) and
// offers the winning (car, floor) pair until the car controller takes it
// (ISSUE).
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. req_ready_o is high whenever reset is low. Once
// assign_valid_o rises, assign_car_o/assign_floor_o stay constant until the
// edge where assign_ready_i is also high.
//
// Build option: define DISPATCH_AGING_EN to add per-floor age counters. A
// floor whose age reaches AGE_MAX is served by the nearest car regardless of
// direction. Without it a floor no car may serve stays pending.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter  int N_CARS   = 3,
  parameter  int FLOOR_W  = 4,
  parameter  int N_FLOORS = 16,
  parameter  int AGE_MAX  = 4,
  localparam int CAR_W    = $clog2(N_CARS),
  localparam int CW       = FLOOR_W + DIR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [FLOOR_W-1:0]   req_floor_i,
  output logic                 req_ready_o,
  input  logic [N_CARS*CW-1:0] car_state_i,
  output logic                 assign_valid_o,
  output logic [CAR_W-1:0]     assign_car_o,
  output logic [FLOOR_W-1:0]   assign_floor_o,
  input  logic                 assign_ready_i,
  output logic [N_FLOORS-1:0]  pending_o,
  output logic                 busy_o,
  output state_e               dbg_state_o
);

  state_e              state_q;
  logic [FLOOR_W-1:0]  ptr_q;
  logic [FLOOR_W-1:0]  obj_q;
  logic [CAR_W-1:0]    idx_q;
  logic                best_valid_q;
  logic [CAR_W-1:0]    best_car_q;
  logic [FLOOR_W-1:0]  best_cost_q;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic                av_q;
  logic [CAR_W-1:0]    ac_q;
  logic [FLOOR_W-1:0]  af_q;

  logic [N_FLOORS-1:0] set_mask, clr_mask;
  logic                handshake;
  logic                scan_hit;
  logic [FLOOR_W-1:0]  scan_obj;
  logic [FLOOR_W-1:0]  next_ptr;
  logic [CW-1:0]       car_word;
  logic                cc_elig;
  logic [FLOOR_W-1:0]  cc_cost;
  logic                force_w;
  logic                take;
  logic                win_valid;
  logic [CAR_W-1:0]    win_car;
  logic                last_car;

  assign req_ready_o    = !rst_i;
  assign assign_valid_o = av_q;
  assign assign_car_o   = ac_q;
  assign assign_floor_o = af_q;
  assign pending_o      = pending_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign dbg_state_o    = state_q;
  assign handshake      = (state_q == ST_ISSUE) && assign_ready_i;
  assign next_ptr       = (obj_q == FLOOR_W'(N_FLOORS - 1)) ? '0 : obj_q + 1'b1;
  assign last_car       = (idx_q == CAR_W'(N_CARS - 1));

  // Pending mask update; a new call wins over the clear of the served floor.
  // Out-of-range floors match no bit and are dropped.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      set_mask[f] = req_valid_i && (req_floor_i == FLOOR_W'(f));
      clr_mask[f] = handshake && (obj_q == FLOOR_W'(f));
    end
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // First pending floor at or after the scan pointer, wrapping around.
  always_comb begin
    scan_hit = 1'b0;
    scan_obj = '0;
    for (int k = N_FLOORS - 1; k >= 0; k--) begin
      if (pending_q[(int'(ptr_q) + k) % N_FLOORS]) begin
        scan_hit = 1'b1;
        scan_obj = FLOOR_W'((int'(ptr_q) + k) % N_FLOORS);
      end
    end
  end

  // Select the state word of the car being evaluated this cycle.
  always_comb begin
    car_word = '0;
    for (int c = 0; c < N_CARS; c++) begin
      if (idx_q == CAR_W'(c)) car_word = car_state_i[car_lsb(c, FLOOR_W) +: CW];
    end
  end

  car_cost #(.FLOOR_W(FLOOR_W)) u_car_cost (
    .floor_i    (car_word[CW-1:FLOOR_LSB]),
    .dir_i      (car_word[DIR_LSB +: DIR_W]),
    .obj_i      (obj_q),
    .force_i    (force_w),
    .eligible_o (cc_elig),
    .cost_o     (cc_cost)
  );

  // Running-best update: strict less-than keeps the lower index on ties.
  always_comb begin
    take      = cc_elig && (!best_valid_q || (cc_cost < best_cost_q));
    win_valid = best_valid_q || cc_elig;
    win_car   = take ? idx_q : best_car_q;
  end

`ifdef DISPATCH_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  logic [AGE_W-1:0] age_q [N_FLOORS];
  logic             pass_failed;

  assign force_w     = (age_q[obj_q] == AGE_W'(AGE_MAX));
  assign pass_failed = (state_q == ST_EVAL) && last_car && !win_valid;

  // Per-floor age: count failed passes (saturating), clear on assignment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int f = 0; f < N_FLOORS; f++) age_q[f] <= '0;
    end else begin
      for (int f = 0; f < N_FLOORS; f++) begin
        if (handshake && (obj_q == FLOOR_W'(f))) begin
          age_q[f] <= '0;
        end else if (pass_failed && (obj_q == FLOOR_W'(f)) &&
                     (age_q[f] != AGE_W'(AGE_MAX))) begin
          age_q[f] <= age_q[f] + 1'b1;
        end
      end
    end
  end
`else
  // Aging compiled out: AGE_MAX is non-negative, so this never forces.
  assign force_w = (AGE_MAX < 0);
`endif

  // Dispatcher FSM with registered offer outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      obj_q        <= '0;
      idx_q        <= '0;
      best_valid_q <= 1'b0;
      best_car_q   <= '0;
      best_cost_q  <= '0;
      pending_q    <= '0;
      av_q         <= 1'b0;
      ac_q         <= '0;
      af_q         <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        ST_IDLE: begin
          if (pending_q != '0) state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_hit) begin
            obj_q        <= scan_obj;
            idx_q        <= '0;
            best_valid_q <= 1'b0;
            state_q      <= ST_EVAL;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          if (take) begin
            best_valid_q <= 1'b1;
            best_car_q   <= idx_q;
            best_cost_q  <= cc_cost;
          end
          if (last_car) begin
            if (win_valid) begin
              av_q    <= 1'b1;
              ac_q    <= win_car;
              af_q    <= obj_q;
              state_q <= ST_ISSUE;
            end else begin
              ptr_q   <= next_ptr;
              state_q <= (pending_d != '0) ? ST_SCAN : ST_IDLE;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (assign_ready_i) begin
            av_q    <= 1'b0;
            ptr_q   <= next_ptr;
            state_q <= (pending_d != '0) ? ST_SCAN : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher (3 cars, 16 floors, AGE_MAX=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_elevator_dispatcher;
  import elevator_pkg::*;

  localparam int N_CARS   = 3;
  localparam int FLOOR_W  = 4;
  localparam int N_FLOORS = 16;
  localparam int CW       = FLOOR_W + 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 req_valid;
  logic [FLOOR_W-1:0]   req_floor;
  logic                 req_ready;
  logic [N_CARS*CW-1:0] car_state;
  logic                 assign_valid;
  logic [1:0]           assign_car;
  logic [FLOOR_W-1:0]   assign_floor;
  logic                 assign_ready;
  logic [N_FLOORS-1:0]  pending;
  logic                 busy;
  state_e               dbg_state;

  elevator_dispatcher #(
    .N_CARS(N_CARS), .FLOOR_W(FLOOR_W), .N_FLOORS(N_FLOORS), .AGE_MAX(4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_floor_i    (req_floor),
    .req_ready_o    (req_ready),
    .car_state_i    (car_state),
    .assign_valid_o (assign_valid),
    .assign_car_o   (assign_car),
    .assign_floor_o (assign_floor),
    .assign_ready_i (assign_ready),
    .pending_o      (pending),
    .busy_o         (busy),
    .dbg_state_o    (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CARS*CW-1:0] cars(
    input logic [3:0] f0, input logic [1:0] d0,
    input logic [3:0] f1, input logic [1:0] d1,
    input logic [3:0] f2, input logic [1:0] d2);
    return {f2, d2, f1, d1, f0, d0};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic call(input logic [FLOOR_W-1:0] f);
    req_floor = f;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles, output int n);
    n = 0;
    while (!assign_valid && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, assign_valid, 1);
  endtask

  task automatic take_offer();
    assign_ready = 1'b1;
    step();
    assign_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic saw;
    req_valid    = 1'b0;
    req_floor    = '0;
    assign_ready = 1'b0;
    car_state    = '0;

    // Reset state
    #1 rst = 1'b1;
    step();
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_valid", assign_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    #1;
    check("req_ready_up", req_ready, 1);

    // 1: nearest eligible car, exact latency k+5
    car_state = cars(4'd2, DIR_UP, 4'd7, DIR_DOWN, 4'd5, DIR_IDLE);
    call(4'd4);
    check("t1_pending", pending, 16'h0010);
    check("t1_busy_k", busy, 0);
    repeat (4) step();
    check("t1_valid_k4", assign_valid, 0);
    check("t1_busy_k4", busy, 1);
    step();
    check("t1_valid_k5", assign_valid, 1);
    check("t1_car", assign_car, 2);
    check("t1_floor", assign_floor, 4);
    take_offer();
    check("t1_valid_after", assign_valid, 0);
    check("t1_pending_after", pending, 0);
    check("t1_busy_after", busy, 0);

    // 2: equal distances, lowest index wins
    car_state = cars(4'd3, DIR_IDLE, 4'd5, DIR_IDLE, 4'd9, DIR_UP);
    call(4'd4);
    wait_valid("t2_valid", 20, n);
    check("t2_latency", n, 5);
    check("t2_car", assign_car, 0);
    check("t2_floor", assign_floor, 4);
    take_offer();

    // 3: no car may serve floor 4
    car_state = cars(4'd6, DIR_UP, 4'd1, DIR_DOWN, 4'd9, DIR_UP);
    call(4'd4);
`ifdef DISPATCH_AGING_EN
    wait_valid("t3_aged_valid", 60, n);
    check("t3_aged_latency", n, 21);
    check("t3_aged_car", assign_car, 0);
    check("t3_aged_floor", assign_floor, 4);
`else
    saw = 1'b0;
    repeat (100) begin
      step();
      if (assign_valid) saw = 1'b1;
    end
    check("t3_no_offer", saw, 0);
    check("t3_pending", pending, 16'h0010);
    check("t3_busy", busy, 1);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t3_reset_pending", pending, 0);

    // 4: three queued calls under backpressure, served in scan order
    car_state = cars(4'd0, DIR_IDLE, 4'd9, DIR_IDLE, 4'd13, DIR_DOWN);
    call(4'd3);
    call(4'd10);
    call(4'd12);
    call(4'd10);
    check("t4_pending", pending, 16'h1408);
    wait_valid("t4_valid3", 10, n);
    check("t4_car3", assign_car, 0);
    check("t4_floor3", assign_floor, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_valid", assign_valid, 1);
      check("t4_hold_car", assign_car, 0);
      check("t4_hold_floor", assign_floor, 3);
    end
    take_offer();
    wait_valid("t4_valid10", 10, n);
    check("t4_car10", assign_car, 1);
    check("t4_floor10", assign_floor, 10);
    take_offer();
    wait_valid("t4_valid12", 10, n);
    check("t4_car12", assign_car, 2);
    check("t4_floor12", assign_floor, 12);
    take_offer();
    check("t4_pending_end", pending, 0);
    check("t4_busy_end", busy, 0);

    // 5: new call to the floor being handed over
    car_state = cars(4'd0, DIR_IDLE, 4'd0, DIR_IDLE, 4'd0, DIR_IDLE);
    call(4'd4);
    wait_valid("t5_valid", 10, n);
    check("t5_floor", assign_floor, 4);
    req_floor    = 4'd4;
    req_valid    = 1'b1;
    assign_ready = 1'b1;
    step();
    req_valid    = 1'b0;
    assign_ready = 1'b0;
    check("t5_pending_kept", pending, 16'h0010);
    check("t5_valid_drop", assign_valid, 0);
    wait_valid("t5_reoffer", 10, n);
    check("t5_reoffer_floor", assign_floor, 4);
    take_offer();
    check("t5_pending_end", pending, 0);

    // 6: asynchronous reset while an offer is up
    call(4'd7);
    wait_valid("t6_valid", 10, n);
    rst = 1'b1;
    #1;
    check("t6_valid", assign_valid, 0);
    check("t6_pending", pending, 0);
    check("t6_busy", busy, 0);
    check("t6_req_ready", req_ready, 0);
    step();
    rst = 1'b0;
    step();
    check("t6_idle_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
